sha_miter_monitor: RTL and testbench
====================================

# sha_miter_monitor

Parametrised N-lane lockstep miter monitor for the SHA cores. It compares the `text_o`/`cmd_o` outputs of `LANES` identically driven core instances against lane 0, starting after a programmable warm-up. On the first divergence it latches a sticky mismatch with the divergent-lane mask, the compare-cycle index and a data snapshot. It sits beside the instantiated cores in multi-copy equivalence and fault-injection harnesses. Unlike a plain two-copy miter, it supports N lanes, warm-up masking, qualified compare and post-mortem capture.

## Interface
- `LANES`, 2, number of lanes compared; lane 0 is the golden lane; must be ≥2.
- `DW`, 32, text width per lane.
- `CW`, 5, cmd/status width per lane.
- `WARMUP`, 4, cycles after arm during which compares are ignored; 0 is allowed.
- `CNT_W`, 32, compare-cycle counter width.
- `QUAL`, 0, 0: compare text and cmd every cycle; 1: cmd always compared, text compared only when lane-0 cmd bit `QUAL_BIT` is 1.
- `QUAL_BIT`, 0, cmd bit used as the text qualifier when `QUAL`=1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `text_i`  in  LANES*DW  packed lane text; lane k is at [k*DW +: DW].
- `cmd_i`  in  LANES*CW  packed lane cmd; lane k is at [k*CW +: CW].
- `arm_i`  in  1  start monitoring; honoured only in IDLE.
- `clear_i`  in  1  return to IDLE and clear all capture.
- `mismatch_o`  out  1  sticky divergence flag.
- `lanes_o`  out  LANES  divergent-lane mask latched at trip; bit 0 is always 0.
- `cnt_o`  out  CNT_W  compare cycles elapsed; frozen at trip.
- `snap_o`  out  DW  lane-0 text at the trip cycle.
- `diff_o`  out  DW  lane-0 text XOR text of the lowest-index divergent lane, at trip.
- `state_o`  out  2  encoding: IDLE=0, WARM=1, ARMED=2, TRIPPED=3.

## Operation
- Per-lane compare, for k ≥ 1: the lane differs if its cmd differs from lane 0, or its text differs from lane 0 while the text compare is enabled (`QUAL`=0, or lane-0 `cmd[QUAL_BIT]`=1).
- State transitions:
  - IDLE, `arm_i` → WARM, with the warm-up counter loaded to `WARMUP`-1. If `WARMUP`=0, go directly to ARMED.
  - WARM: decrement each cycle; from 0 → ARMED. Compare results are ignored throughout WARM.
  - ARMED, no lane differs: `cnt_o` increments, saturating at all-ones.
  - ARMED, any lane differs → TRIPPED. In the same edge, latch `mismatch_o`=1, `lanes_o`=differ mask, `snap_o`, and `diff_o`. `cnt_o` holds the index of the divergent compare cycle (0-based).
  - TRIPPED: all outputs frozen until `clear_i` or reset. Further differences are ignored.
- `clear_i` in any state → IDLE and all outputs zeroed. `clear_i` has priority over `arm_i` and over a simultaneous trip.
- `arm_i` outside IDLE is ignored.

## Timing
- Reset value of every output is 0, with `state_o`=IDLE. The asynchronous assertion of reset clears state immediately, including mid-WARM or TRIPPED. After deassertion the block stays in IDLE until `arm_i`.
- All outputs are registered. A difference sampled at edge t is visible on `mismatch_o` after edge t.
- The first compared sample is the one at the edge where the state is ARMED. With `WARMUP`=W ≥1, this is W+1 edges after the arm edge. With `WARMUP`=0, it is 1 edge after the arm edge.
- The counter is saturating, not wrapping; saturation does not trip.
- Inputs are sampled with no handshake. Lanes are assumed to be cycle-aligned by the harness.

## Structure
- The package `sha_miter_pkg` holds the state enum, the encoding constants and the lane-slice helper functions.
- A natural sub-module is `sha_miter_lane_cmp`: a combinational per-lane equality with the qualifier, generated for lanes 1..`LANES`-1. The monitor's FSM, counters and capture registers are in the top level.
- The lowest-index divergent-lane select is a priority encoder in the top level.

## Test plan
All scenarios use `LANES`=3, `DW`=32, `CW`=5, `WARMUP`=4, `QUAL`=0 unless stated.

1. Assert `rst_i` low, then release → all outputs 0, `state_o`=0; with no `arm_i` the block stays in IDLE with the counter 0.
2. Arm, then drive identical lanes for 100 compare cycles → `mismatch_o`=0, `cnt_o`=100, `state_o`=2.
3. Arm, then set lane 2 text=32'h0000_00F0 vs lane 0 text=32'h0000_0000 at compare cycle 7 → `mismatch_o`=1, `lanes_o`=3'b100, `cnt_o`=7, `snap_o`=0, `diff_o`=32'h0000_00F0. All are frozen 20 cycles later.
4. Lane 1 cmd differs during warm-up cycles 0–3 only → no trip, and `cnt_o` starts at 0 in ARMED.
5. With `QUAL`=1 and `QUAL_BIT`=0: text differs while lane-0 cmd[0]=0 → no trip; the same difference with cmd[0]=1 → trip, `lanes_o`=3'b010.
6. In TRIPPED, assert `clear_i` and `arm_i` in the same cycle → IDLE, all outputs 0. Next, assert `arm_i` → WARM. Then pull `rst_i` low mid-WARM → IDLE immediately.

Source files
------------

// File: rtl/sha_miter_pkg.sv
// ---------------------------------------------------------------------------
// sha_miter_pkg
// Shared definitions for the SHA lockstep miter monitor: the monitor state
// enum (its encoding is visible on state_o) and the helper that locates a
// lane's slice inside the packed lane buses.
// ---------------------------------------------------------------------------
package sha_miter_pkg;

    // Monitor states; the numeric values are the ones reported on state_o
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARM    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_TRIPPED = 2'd3
    } miterState_t;

    localparam int STATE_W = 2;

    // Lowest bit index of lane 'lane' in a bus packing lanes of 'width' bits
    function automatic int laneLsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sha_miter_lane_cmp.sv
// ---------------------------------------------------------------------------
// sha_miter_lane_cmp
// Combinational compare of one lane against the golden lane 0. The lane
// differs when its cmd differs, or when its text differs while the text
// compare is enabled (always with QUAL=0, else only when golden
// cmd[QUAL_BIT] is 1).
//
// Ports:
//   i_refText  DW  golden (lane 0) text
//   i_refCmd   CW  golden (lane 0) cmd
//   i_laneText DW  text of the lane under test
//   i_laneCmd  CW  cmd of the lane under test
//   o_differ   1   lane under test diverges from lane 0
// ---------------------------------------------------------------------------
module sha_miter_lane_cmp
    import sha_miter_pkg::*;
#(
    parameter int DW       = 32,
    parameter int CW       = 5,
    parameter int QUAL     = 0,
    parameter int QUAL_BIT = 0
) (
    input  logic [DW-1:0] i_refText,
    input  logic [CW-1:0] i_refCmd,
    input  logic [DW-1:0] i_laneText,
    input  logic [CW-1:0] i_laneCmd,
    output logic          o_differ
);

    logic w_textEn;

    // Text is only meaningful when the golden lane qualifies it
    always_comb begin
        w_textEn = (QUAL == 0) || i_refCmd[QUAL_BIT];
        o_differ = (i_laneCmd != i_refCmd) || (w_textEn && (i_laneText != i_refText));
    end

endmodule

// File: rtl/sha_miter_monitor.sv
// ---------------------------------------------------------------------------
// sha_miter_monitor
// N-lane lockstep miter. After arm and an optional warm-up, every cycle the
// lanes 1..LANES-1 are compared with lane 0; the first divergence freezes a
// post-mortem capture (lane mask, compare index, lane-0 text, XOR diff)
// until clear or reset.
//
// Ports:
//   clk_i       1          clock, rising edge
//   rst_i       1          asynchronous active-low reset
//   text_i      LANES*DW   packed lane text, lane k at [k*DW +: DW]
//   cmd_i       LANES*CW   packed lane cmd,  lane k at [k*CW +: CW]
//   arm_i       1          start monitoring (IDLE only)
//   clear_i     1          back to IDLE, capture cleared (highest priority)
//   mismatch_o  1          sticky divergence flag
//   lanes_o     LANES      divergent-lane mask at trip (bit 0 always 0)
//   cnt_o       CNT_W      compare cycles elapsed, frozen at trip
//   snap_o      DW         lane-0 text at trip
//   diff_o      DW         lane-0 text XOR lowest divergent lane text
//   state_o     2          IDLE=0, WARM=1, ARMED=2, TRIPPED=3
// ---------------------------------------------------------------------------
module sha_miter_monitor
    import sha_miter_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int DW       = 32,
    parameter int CW       = 5,
    parameter int WARMUP   = 4,
    parameter int CNT_W    = 32,
    parameter int QUAL     = 0,
    parameter int QUAL_BIT = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LANES*DW-1:0] text_i,
    input  logic [LANES*CW-1:0] cmd_i,
    input  logic                arm_i,
    input  logic                clear_i,
    output logic                mismatch_o,
    output logic [LANES-1:0]    lanes_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [DW-1:0]       snap_o,
    output logic [DW-1:0]       diff_o,
    output logic [STATE_W-1:0]  state_o
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WARM_W-1:0] WARM_LOAD = (WARMUP > 0) ? WARM_W'(WARMUP - 1) : '0;

    miterState_t       r_state;
    miterState_t       w_nextState;
    logic [WARM_W-1:0] r_warmCnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mismatch;
    logic [LANES-1:0]  r_lanes;
    logic [DW-1:0]     r_snap;
    logic [DW-1:0]     r_diff;

    logic [LANES-1:0]  w_differ;
    logic              w_anyDiffer;
    logic [DW-1:0]     w_diffText;
    logic              w_loadWarm;
    logic              w_decWarm;
    logic              w_countUp;
    logic              w_capture;
    logic              w_clearAll;

    // Lane 0 is the reference and can never diverge from itself
    assign w_differ[0] = 1'b0;

    for (genvar k = 1; k < LANES; k++) begin : g_lane
        sha_miter_lane_cmp #(
            .DW       (DW),
            .CW       (CW),
            .QUAL     (QUAL),
            .QUAL_BIT (QUAL_BIT)
        ) u_cmp (
            .i_refText  (text_i[DW-1:0]),
            .i_refCmd   (cmd_i[CW-1:0]),
            .i_laneText (text_i[laneLsb(k, DW) +: DW]),
            .i_laneCmd  (cmd_i[laneLsb(k, CW) +: CW]),
            .o_differ   (w_differ[k])
        );
    end

    assign w_anyDiffer = |w_differ;

    // Priority select: walking from the top lane down lets the lowest
    // divergent lane overwrite any higher one
    always_comb begin
        w_diffText = '0;
        for (int k = LANES - 1; k >= 1; k--) begin
            if (w_differ[k]) begin
                w_diffText = text_i[DW-1:0] ^ text_i[laneLsb(k, DW) +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; clear wins over arm and over a trip in the same cycle
    always_comb begin
        w_nextState = r_state;
        if (clear_i) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (arm_i) w_nextState = (WARMUP == 0) ? ST_ARMED : ST_WARM;
                ST_WARM:    if (r_warmCnt == '0) w_nextState = ST_ARMED;
                ST_ARMED:   if (w_anyDiffer) w_nextState = ST_TRIPPED;
                ST_TRIPPED: w_nextState = ST_TRIPPED;
                default:    w_nextState = ST_IDLE;
            endcase
        end
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        w_loadWarm = 1'b0;
        w_decWarm  = 1'b0;
        w_countUp  = 1'b0;
        w_capture  = 1'b0;
        w_clearAll = 1'b0;
        if (clear_i) begin
            w_clearAll = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:  w_loadWarm = arm_i;
                ST_WARM:  w_decWarm  = 1'b1;
                ST_ARMED: begin
                    w_capture = w_anyDiffer;
                    w_countUp = ~w_anyDiffer;
                end
                default: ;
            endcase
        end
    end

    // Warm-up counter, saturating compare counter and trip capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_warmCnt  <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_lanes    <= '0;
            r_snap     <= '0;
            r_diff     <= '0;
        end else if (w_clearAll) begin
            r_warmCnt  <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_lanes    <= '0;
            r_snap     <= '0;
            r_diff     <= '0;
        end else begin
            if (w_loadWarm) begin
                r_warmCnt <= WARM_LOAD;
            end else if (w_decWarm && (r_warmCnt != '0)) begin
                r_warmCnt <= r_warmCnt - 1'b1;
            end
            if (w_countUp && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_mismatch <= 1'b1;
                r_lanes    <= w_differ;
                r_snap     <= text_i[DW-1:0];
                r_diff     <= w_diffText;
            end
        end
    end

    assign mismatch_o = r_mismatch;
    assign lanes_o    = r_lanes;
    assign cnt_o      = r_cnt;
    assign snap_o     = r_snap;
    assign diff_o     = r_diff;
    assign state_o    = r_state;

endmodule

// File: tb/tb_sha_miter_monitor.sv
// ---------------------------------------------------------------------------
// tb_sha_miter_monitor
// Three monitors share one 3-lane stimulus bus:
//   dut0: WARMUP=4, QUAL=0, CNT_W=32
//   dut1: WARMUP=4, QUAL=1 (QUAL_BIT=0), CNT_W=32
//   dut2: WARMUP=0, QUAL=0, CNT_W=4 (exercises counter saturation)
// Each edge the reference model predicts every output bundle and queues it;
// the monitor process pops on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_sha_miter_monitor;

    localparam int LANES = 3;
    localparam int DW    = 32;
    localparam int CW    = 5;

    typedef logic [101:0] bundle_t;
    typedef struct packed {
        bundle_t d2;
        bundle_t d1;
        bundle_t d0;
    } expSet_t;

    typedef struct {
        bit          armed;
        int          since;
        bit          tripped;
        logic [2:0]  lanes;
        logic [31:0] cnt;
        logic [31:0] snap;
        logic [31:0] diff;
    } model_t;

    logic                clk = 1'b0;
    logic                rstN;
    logic                clrIn;
    logic                armIn;
    logic [LANES*DW-1:0] textBus;
    logic [LANES*CW-1:0] cmdBus;

    logic        mis0, mis1, mis2;
    logic [2:0]  lanes0, lanes1, lanes2;
    logic [31:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    logic [31:0] snap0, snap1, snap2;
    logic [31:0] diff0, diff1, diff2;
    logic [1:0]  state0, state1, state2;

    model_t      m[3];
    int          warmOf[3] = '{4, 4, 0};
    bit          qualOf[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] cmaxOf[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};
    expSet_t     expQ[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha_miter_monitor #(.LANES(3), .DW(32), .CW(5), .WARMUP(4), .CNT_W(32), .QUAL(0), .QUAL_BIT(0)) dut0 (
        .clk_i(clk), .rst_i(rstN), .text_i(textBus), .cmd_i(cmdBus), .arm_i(armIn), .clear_i(clrIn),
        .mismatch_o(mis0), .lanes_o(lanes0), .cnt_o(cnt0), .snap_o(snap0), .diff_o(diff0), .state_o(state0));

    sha_miter_monitor #(.LANES(3), .DW(32), .CW(5), .WARMUP(4), .CNT_W(32), .QUAL(1), .QUAL_BIT(0)) dut1 (
        .clk_i(clk), .rst_i(rstN), .text_i(textBus), .cmd_i(cmdBus), .arm_i(armIn), .clear_i(clrIn),
        .mismatch_o(mis1), .lanes_o(lanes1), .cnt_o(cnt1), .snap_o(snap1), .diff_o(diff1), .state_o(state1));

    sha_miter_monitor #(.LANES(3), .DW(32), .CW(5), .WARMUP(0), .CNT_W(4), .QUAL(0), .QUAL_BIT(0)) dut2 (
        .clk_i(clk), .rst_i(rstN), .text_i(textBus), .cmd_i(cmdBus), .arm_i(armIn), .clear_i(clrIn),
        .mismatch_o(mis2), .lanes_o(lanes2), .cnt_o(cnt2), .snap_o(snap2), .diff_o(diff2), .state_o(state2));

    // Reference model: 'since' counts edges after the arm edge; the monitor
    // compares on an edge once 'since' has reached the warm-up length
    function automatic void modelClear(int d);
        m[d].armed   = 1'b0;
        m[d].since   = 0;
        m[d].tripped = 1'b0;
        m[d].lanes   = '0;
        m[d].cnt     = '0;
        m[d].snap    = '0;
        m[d].diff    = '0;
    endfunction

    function automatic void modelStep(int d);
        logic [2:0]  dm;
        bit          textEn;
        int          first;
        logic [31:0] t0;
        t0 = textBus[31:0];
        if (!rstN || clrIn) begin
            modelClear(d);
            return;
        end
        if (!m[d].armed) begin
            if (armIn) begin
                m[d].armed = 1'b1;
                m[d].since = 0;
            end
            return;
        end
        if (m[d].tripped) return;
        if (m[d].since >= warmOf[d]) begin
            textEn = !qualOf[d] || cmdBus[0];
            dm     = '0;
            first  = 0;
            for (int k = 1; k < LANES; k++) begin
                if ((cmdBus[k*CW +: CW] != cmdBus[CW-1:0]) || (textEn && (textBus[k*DW +: DW] != t0))) begin
                    dm[k] = 1'b1;
                    if (first == 0) first = k;
                end
            end
            if (dm != '0) begin
                m[d].tripped = 1'b1;
                m[d].lanes   = dm;
                m[d].snap    = t0;
                m[d].diff    = t0 ^ textBus[first*DW +: DW];
            end else if (m[d].cnt < cmaxOf[d]) begin
                m[d].cnt = m[d].cnt + 32'd1;
            end
        end
        m[d].since++;
    endfunction

    function automatic bundle_t expOf(int d);
        logic [1:0] st;
        if (!m[d].armed)                 st = 2'd0;
        else if (m[d].tripped)           st = 2'd3;
        else if (m[d].since >= warmOf[d]) st = 2'd2;
        else                             st = 2'd1;
        return {m[d].tripped, m[d].lanes, m[d].cnt, m[d].snap, m[d].diff, st};
    endfunction

    function automatic bundle_t actOf(int d);
        case (d)
            0:       return {mis0, lanes0, cnt0, snap0, diff0, state0};
            1:       return {mis1, lanes1, cnt1, snap1, diff1, state1};
            default: return {mis2, lanes2, 28'd0, cnt2, snap2, diff2, state2};
        endcase
    endfunction

    function automatic logic [95:0] rep3t(logic [31:0] t);
        return {t, t, t};
    endfunction

    function automatic logic [14:0] rep3c(logic [4:0] c);
        return {c, c, c};
    endfunction

    // Compare one output bundle and report it field by field on a miss
    task automatic checkOutput(input string name, input bundle_t act, input bundle_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s got mis=%0b lanes=%b cnt=%0d snap=%h diff=%h state=%0d required mis=%0b lanes=%b cnt=%0d snap=%h diff=%h state=%0d",
                     name, act[101], act[100:98], act[97:66], act[65:34], act[33:2], act[1:0],
                     req[101], req[100:98], req[97:66], req[65:34], req[33:2], req[1:0]);
        end
    endtask

    // Drive one cycle of inputs, then advance the model on the sampling edge
    task automatic applyStimulus(input bit r, input bit c, input bit a,
                                 input logic [95:0] t, input logic [14:0] cm);
        expSet_t e;
        rstN    = r;
        clrIn   = c;
        armIn   = a;
        textBus = t;
        cmdBus  = cm;
        @(posedge clk);
        for (int d = 0; d < 3; d++) modelStep(d);
        e.d0 = expOf(0);
        e.d1 = expOf(1);
        e.d2 = expOf(2);
        expQ.push_back(e);
        #1;
    endtask

    task automatic idleCycles(input int n, input bit c, input bit a);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, c, a, rep3t($urandom), rep3c(5'($urandom_range(0, 31))));
    endtask

    // Scoreboard monitor: one queued expectation per clock edge
    initial begin
        expSet_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_dut0", actOf(0), e.d0);
                checkOutput("sb_dut1", actOf(1), e.d1);
                checkOutput("sb_dut2", actOf(2), e.d2);
            end
        end
    end

    initial begin
        logic [31:0] tt[3];
        logic [4:0]  cc[3];
        logic [31:0] t0;
        logic [4:0]  c0;

        for (int d = 0; d < 3; d++) modelClear(d);
        rstN = 1'b1; clrIn = 1'b0; armIn = 1'b0; textBus = '0; cmdBus = '0;
        #2 rstN = 1'b0;

        // Reset, then idle with no arm
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("reset_dut0", actOf(0), '0);
        idleCycles(5, 1'b0, 1'b0);
        checkOutput("idle_no_arm", actOf(0), '0);

        // 100 identical compare cycles
        idleCycles(1, 1'b0, 1'b1);
        idleCycles(4 + 100, 1'b0, 1'b0);
        checkOutput("clean100_dut0", actOf(0), {1'b0, 3'b000, 32'd100, 32'd0, 32'd0, 2'd2});
        checkOutput("sat_dut2", actOf(2), {1'b0, 3'b000, 32'd15, 32'd0, 32'd0, 2'd2});

        // Lane 2 text diverges at compare cycle 7
        idleCycles(1, 1'b1, 1'b0);
        idleCycles(1, 1'b0, 1'b1);
        idleCycles(4 + 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, {32'h0000_00F0, 32'h0, 32'h0}, '0);
        checkOutput("trip_lane2", actOf(0), {1'b1, 3'b100, 32'd7, 32'd0, 32'h0000_00F0, 2'd3});
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, {$urandom, $urandom, $urandom}, 15'($urandom));
        checkOutput("trip_frozen", actOf(0), {1'b1, 3'b100, 32'd7, 32'd0, 32'h0000_00F0, 2'd3});

        // Cmd difference confined to warm-up
        idleCycles(1, 1'b1, 1'b0);
        idleCycles(1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, {5'd3, 5'd2, 5'd3});
        checkOutput("warm_masked", actOf(0), {1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 2'd2});
        idleCycles(3, 1'b0, 1'b0);
        checkOutput("warm_then_count", actOf(0), {1'b0, 3'b000, 32'd3, 32'd0, 32'd0, 2'd2});

        // Qualified text compare on dut1
        idleCycles(1, 1'b1, 1'b0);
        idleCycles(1, 1'b0, 1'b1);
        idleCycles(4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, {32'h1234_5678, 32'h1234_5670, 32'h1234_5678}, rep3c(5'b00000));
        checkOutput("qual_off", actOf(1), {1'b0, 3'b000, 32'd1, 32'd0, 32'd0, 2'd2});
        applyStimulus(1'b1, 1'b0, 1'b0, {32'h1234_5678, 32'h1234_5670, 32'h1234_5678}, rep3c(5'b00001));
        checkOutput("qual_on", actOf(1), {1'b1, 3'b010, 32'd1, 32'h1234_5678, 32'h0000_0008, 2'd3});

        // Clear beats arm, then async reset mid-warm-up
        idleCycles(1, 1'b1, 1'b1);
        checkOutput("clear_arm_dut1", actOf(1), '0);
        checkOutput("clear_arm_dut0", actOf(0), '0);
        idleCycles(1, 1'b0, 1'b1);
        checkOutput("rearm_warm", actOf(1), {1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 2'd1});
        idleCycles(1, 1'b0, 1'b0);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_rst_dut0", actOf(0), '0);
        checkOutput("async_rst_dut2", actOf(2), '0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        idleCycles(2, 1'b0, 1'b0);

        // Randomized phase: mostly equal lanes with sparse divergences
        for (int i = 0; i < 600; i++) begin
            t0 = $urandom;
            c0 = 5'($urandom_range(0, 31));
            for (int k = 0; k < 3; k++) begin
                tt[k] = t0;
                cc[k] = c0;
            end
            for (int k = 1; k < 3; k++) begin
                if ($urandom_range(0, 19) == 0) tt[k] = tt[k] ^ (32'd1 << $urandom_range(0, 31));
                if ($urandom_range(0, 29) == 0) cc[k] = cc[k] ^ (5'd1 << $urandom_range(0, 4));
            end
            applyStimulus(1'b1, $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                          {tt[2], tt[1], tt[0]}, {cc[2], cc[1], cc[0]});
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
